// File: rtl/ddr_burst_arb_pkg.sv
// ddr_arb_pkg: shared widths, arbiter state encoding and the round-robin
// pick helper used by the DDR burst arbiter.
package ddr_arb_pkg;

    localparam int ADDR_W    = 25;
    localparam int LEN_W     = 10;
    localparam int DATA_W    = 32;
    localparam int MAX_PORTS = 8;
    localparam int PTR_W     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    // One-hot winner among req[n-1:0]: the first set bit at or after ptr,
    // wrapping at n. Each step rotates by ptr, keeps only the first hit and
    // maps the hit back to its absolute position.
    function automatic logic [MAX_PORTS-1:0] rr_pick(
        input logic [MAX_PORTS-1:0] req,
        input logic [PTR_W-1:0]     ptr,
        input logic [PTR_W:0]       n
    );
        logic [MAX_PORTS-1:0] gnt;
        logic                 found;
        logic [PTR_W+1:0]     idx;
        gnt   = {MAX_PORTS{1'b0}};
        found = 1'b0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            idx = {2'b00, ptr} + (PTR_W+2)'(k);
            if (idx >= {1'b0, n}) begin
                idx = idx - {1'b0, n};
            end else begin
                idx = idx;
            end
            if (!found && ((PTR_W+2)'(k) < {1'b0, n}) && req[idx[PTR_W-1:0]]) begin
                gnt[idx[PTR_W-1:0]] = 1'b1;
                found               = 1'b1;
            end else begin
                found = found;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/ddr_burst_arb_if.sv
// ddr_burst_arb_if: burst channel between the arbiter (master) and the DDR
// controller (slave). Write and read bursts use separate request/finish pairs.
interface ddr_burst_arb_if;
    import ddr_arb_pkg::*;

    logic              wr_burst_req;
    logic [ADDR_W-1:0] wr_burst_addr;
    logic [LEN_W-1:0]  wr_burst_len;
    logic [DATA_W-1:0] wr_burst_data;
    logic              wr_burst_data_req;
    logic              wr_burst_finish;

    logic              rd_burst_req;
    logic [ADDR_W-1:0] rd_burst_addr;
    logic [LEN_W-1:0]  rd_burst_len;
    logic              rd_burst_data_valid;
    logic [DATA_W-1:0] rd_burst_data;
    logic              rd_burst_finish;

    modport master (
        output wr_burst_req, wr_burst_addr, wr_burst_len, wr_burst_data,
        output rd_burst_req, rd_burst_addr, rd_burst_len,
        input  wr_burst_data_req, wr_burst_finish,
        input  rd_burst_data_valid, rd_burst_data, rd_burst_finish
    );

    modport slave (
        input  wr_burst_req, wr_burst_addr, wr_burst_len, wr_burst_data,
        input  rd_burst_req, rd_burst_addr, rd_burst_len,
        output wr_burst_data_req, wr_burst_finish,
        output rd_burst_data_valid, rd_burst_data, rd_burst_finish
    );

endinterface

// File: rtl/ddr_burst_arb_rr_pick.sv
// ddr_arb_rr_pick: combinational round-robin selector over N_PORTS
// requesters; returns the one-hot winner at or after ptr_i.
module ddr_arb_rr_pick
    import ddr_arb_pkg::*;
#(
    parameter int N_PORTS = 4
) (
    input  logic [N_PORTS-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [N_PORTS-1:0] gnt_o
);

    localparam logic [PTR_W:0] NP_L = (PTR_W+1)'(N_PORTS);

    // Rotate, priority-encode and rotate back through the package helper.
    always_comb begin
        gnt_o = N_PORTS'(rr_pick(MAX_PORTS'(req_i), ptr_i, NP_L));
    end

endmodule

// File: rtl/ddr_burst_arb.sv
// ddr_burst_arb: round-robin arbiter sharing one DDR controller burst port
// between N_PORTS requesters (2..8). One burst is owned at a time; priority
// rotates to owner+1 after every burst, zero-length requests included.
// Optional build macro DDR_ARB_RD_PRIO_EN: pending reads beat all writes,
// round-robin applies within each direction.
module ddr_burst_arb
    import ddr_arb_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int MAX_LEN = 256
) (
    input  logic                      phy_clk,
    input  logic                      rst,
    input  logic [N_PORTS-1:0]        port_req,
    input  logic [N_PORTS-1:0]        port_we,
    input  logic [N_PORTS*ADDR_W-1:0] port_addr,
    input  logic [N_PORTS*LEN_W-1:0]  port_len,
    input  logic [N_PORTS*DATA_W-1:0] port_wdata,
    output logic [N_PORTS-1:0]        port_grant,
    output logic [N_PORTS-1:0]        port_wdata_req,
    output logic [N_PORTS-1:0]        port_rdata_valid,
    output logic [DATA_W-1:0]         port_rdata,
    output logic [N_PORTS-1:0]        port_finish,
    input  logic                      ddr_init_done,
    ddr_burst_arb_if.master           ddr
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_PORTS - 1);

    arb_state_e          state_q,  state_d;
    logic [N_PORTS-1:0]  grant_q,  grant_d;
    logic [PTR_W-1:0]    owner_q,  owner_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                we_q,     we_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [LEN_W-1:0]    len_q,    len_d;
    logic                wr_req_q, wr_req_d;
    logic                rd_req_q, rd_req_d;
    logic [N_PORTS-1:0]  finish_q, finish_d;

    logic [N_PORTS-1:0]  pick_s;
    logic [PTR_W-1:0]    sel_idx_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [LEN_W-1:0]    sel_len_s;
    logic [LEN_W-1:0]    sel_len_clamp_s;
    logic [DATA_W-1:0]   wdata_s;

`ifdef DDR_ARB_RD_PRIO_EN
    logic [N_PORTS-1:0]  rd_set_s;
    logic [N_PORTS-1:0]  wr_set_s;
    logic [N_PORTS-1:0]  rd_pick_s;
    logic [N_PORTS-1:0]  wr_pick_s;

    assign rd_set_s = port_req & ~port_we;
    assign wr_set_s = port_req &  port_we;

    ddr_arb_rr_pick #(.N_PORTS(N_PORTS)) u_pick_rd (
        .req_i (rd_set_s),
        .ptr_i (rr_ptr_q),
        .gnt_o (rd_pick_s)
    );

    ddr_arb_rr_pick #(.N_PORTS(N_PORTS)) u_pick_wr (
        .req_i (wr_set_s),
        .ptr_i (rr_ptr_q),
        .gnt_o (wr_pick_s)
    );

    // Any pending read wins; writes are considered only when no read waits.
    always_comb begin
        if (|rd_set_s) begin
            pick_s = rd_pick_s;
        end else begin
            pick_s = wr_pick_s;
        end
    end
`else
    ddr_arb_rr_pick #(.N_PORTS(N_PORTS)) u_pick (
        .req_i (port_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_s)
    );
`endif

    // Decode the winner's index and request fields, clamping its length.
    always_comb begin
        sel_idx_s  = {PTR_W{1'b0}};
        sel_we_s   = 1'b0;
        sel_addr_s = {ADDR_W{1'b0}};
        sel_len_s  = {LEN_W{1'b0}};
        for (int i = 0; i < N_PORTS; i++) begin
            if (pick_s[i]) begin
                sel_idx_s  = PTR_W'(i);
                sel_we_s   = port_we[i];
                sel_addr_s = port_addr[i*ADDR_W +: ADDR_W];
                sel_len_s  = port_len[i*LEN_W +: LEN_W];
            end else begin
                sel_idx_s  = sel_idx_s;
            end
        end
        if (sel_len_s > MAX_LEN_L) begin
            sel_len_clamp_s = MAX_LEN_L;
        end else begin
            sel_len_clamp_s = sel_len_s;
        end
    end

    // Next-state and registered-output logic of the burst FSM.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        we_d     = we_q;
        addr_d   = addr_q;
        len_d    = len_q;
        wr_req_d = wr_req_q;
        rd_req_d = rd_req_q;
        finish_d = {N_PORTS{1'b0}};
        case (state_q)
            IDLE: begin
                if (ddr_init_done && (|port_req)) begin
                    grant_d = pick_s;
                    owner_d = sel_idx_s;
                    we_d    = sel_we_s;
                    addr_d  = sel_addr_s;
                    len_d   = sel_len_clamp_s;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (len_q == {LEN_W{1'b0}}) begin
                    state_d = DONE;
                end else begin
                    wr_req_d = we_q;
                    rd_req_d = ~we_q;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // Only the finish of the channel in use ends the burst.
                if (we_q && ddr.wr_burst_finish) begin
                    wr_req_d = 1'b0;
                    state_d  = DONE;
                end else if (!we_q && ddr.rd_burst_finish) begin
                    rd_req_d = 1'b0;
                    state_d  = DONE;
                end else begin
                    state_d  = BUSY;
                end
            end
            DONE: begin
                finish_d = grant_q;
                grant_d  = {N_PORTS{1'b0}};
                if (owner_q == LAST_IDX) begin
                    rr_ptr_d = {PTR_W{1'b0}};
                end else begin
                    rr_ptr_d = owner_q + PTR_W'(1);
                end
                state_d  = IDLE;
            end
            default: begin
                grant_d  = {N_PORTS{1'b0}};
                wr_req_d = 1'b0;
                rd_req_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and latched burst registers with synchronous reset.
    always_ff @(posedge phy_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= {N_PORTS{1'b0}};
            owner_q  <= {PTR_W{1'b0}};
            rr_ptr_q <= {PTR_W{1'b0}};
            we_q     <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            len_q    <= {LEN_W{1'b0}};
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            finish_q <= {N_PORTS{1'b0}};
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            wr_req_q <= wr_req_d;
            rd_req_q <= rd_req_d;
            finish_q <= finish_d;
        end
    end

    // Owner's write data onto the controller bus; zero while nothing is granted.
    always_comb begin
        wdata_s = {DATA_W{1'b0}};
        for (int i = 0; i < N_PORTS; i++) begin
            wdata_s = wdata_s | (port_wdata[i*DATA_W +: DATA_W] & {DATA_W{grant_q[i]}});
        end
    end

    assign port_grant       = grant_q;
    assign port_finish      = finish_q;
    assign port_wdata_req   = {N_PORTS{ddr.wr_burst_data_req}}   & grant_q & {N_PORTS{we_q}};
    assign port_rdata_valid = {N_PORTS{ddr.rd_burst_data_valid}} & grant_q & {N_PORTS{~we_q}};
    assign port_rdata       = ddr.rd_burst_data;

    assign ddr.wr_burst_req  = wr_req_q;
    assign ddr.wr_burst_addr = addr_q;
    assign ddr.wr_burst_len  = len_q;
    assign ddr.wr_burst_data = wdata_s;
    assign ddr.rd_burst_req  = rd_req_q;
    assign ddr.rd_burst_addr = addr_q;
    assign ddr.rd_burst_len  = len_q;

endmodule

// File: tb/tb_ddr_burst_arb.sv
// tb_ddr_burst_arb: directed bench for ddr_burst_arb with a transaction-level
// arbitration model, a DDR controller model driven from tasks, and a per-cycle
// routing comparison against the model's expected owner.
module tb_ddr_burst_arb;
    import ddr_arb_pkg::*;

    localparam int N = 4;

    logic               phy_clk = 1'b0;
    logic               rst;
    logic [N-1:0]       port_req;
    logic [N-1:0]       port_we;
    logic [N*25-1:0]    port_addr;
    logic [N*10-1:0]    port_len;
    logic [N*32-1:0]    port_wdata;
    logic [N-1:0]       port_grant;
    logic [N-1:0]       port_wdata_req;
    logic [N-1:0]       port_rdata_valid;
    logic [31:0]        port_rdata;
    logic [N-1:0]       port_finish;
    logic               ddr_init_done;

    ddr_burst_arb_if ddr();

    ddr_burst_arb #(.N_PORTS(N), .MAX_LEN(256)) dut (
        .phy_clk          (phy_clk),
        .rst              (rst),
        .port_req         (port_req),
        .port_we          (port_we),
        .port_addr        (port_addr),
        .port_len         (port_len),
        .port_wdata       (port_wdata),
        .port_grant       (port_grant),
        .port_wdata_req   (port_wdata_req),
        .port_rdata_valid (port_rdata_valid),
        .port_rdata       (port_rdata),
        .port_finish      (port_finish),
        .ddr_init_done    (ddr_init_done),
        .ddr              (ddr)
    );

    always #5 phy_clk = ~phy_clk;

    int   total = 0;
    int   bad   = 0;
    int   model_ptr = 0;
    int   exp_owner = 0;
    logic exp_we    = 1'b0;
    logic chk_en    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge phy_clk);
        #1;
    endtask

    function automatic logic [N-1:0] onehot(input int p);
        logic [N-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    // Arbitration rule: first candidate at or after ptr, wrapping mod N.
    function automatic int model_winner(input logic [N-1:0] req, input logic [N-1:0] we, input int ptr);
        logic [N-1:0] cand;
        cand = req;
`ifdef DDR_ARB_RD_PRIO_EN
        if ((req & ~we) != '0) cand = req & ~we;
`endif
        for (int k = 0; k < N; k++) begin
            if (cand[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_port(input int p, input logic we, input logic [24:0] addr, input logic [9:0] len);
        port_we[p]              = we;
        port_addr[p*25 +: 25]   = addr;
        port_len[p*10 +: 10]    = len;
        port_wdata[p*32 +: 32]  = 32'hBAD0_0000 + 32'(p);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"},  port_grant, '0);
        check({tag, "_finish"}, port_finish, '0);
        check({tag, "_wdreq"},  port_wdata_req, '0);
        check({tag, "_rvld"},   port_rdata_valid, '0);
        check({tag, "_wrreq"},  ddr.wr_burst_req, 1'b0);
        check({tag, "_rdreq"},  ddr.rd_burst_req, 1'b0);
        check({tag, "_waddr"},  ddr.wr_burst_addr, '0);
        check({tag, "_wlen"},   ddr.wr_burst_len, '0);
        check({tag, "_raddr"},  ddr.rd_burst_addr, '0);
        check({tag, "_rlen"},   ddr.rd_burst_len, '0);
        check({tag, "_wdata"},  ddr.wr_burst_data, '0);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1;
        port_req = '0; port_we = '0; port_addr = '0; port_len = '0; port_wdata = '0;
        ddr_init_done = 1'b1;
        ddr.wr_burst_data_req = 1'b0; ddr.wr_burst_finish = 1'b0;
        ddr.rd_burst_data_valid = 1'b0; ddr.rd_burst_data = '0; ddr.rd_burst_finish = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_all_zero("reset");
        model_ptr = 0;
    endtask

    // One complete burst for port p, acting as requester and DDR controller.
    task automatic run_burst(input int p, input logic keep_req, output int words, output int waited);
        logic        we;
        logic [24:0] addr;
        int          exp_len;
        we      = port_we[p];
        addr    = port_addr[p*25 +: 25];
        exp_len = (port_len[p*10 +: 10] > 10'd256) ? 256 : int'(port_len[p*10 +: 10]);
        exp_owner = p;
        exp_we    = we;
        chk_en    = 1'b1;
        words  = 0;
        waited = 0;
        while (port_grant == '0 && waited < 20) begin
            tick();
            waited++;
        end
        check("grant", port_grant, onehot(p));
        if (exp_len == 0) begin
            tick();
            check("zl_no_dnreq", {ddr.wr_burst_req, ddr.rd_burst_req}, 2'b00);
            tick();
            check("zl_finish", port_finish, onehot(p));
        end else begin
            tick();
            check("dn_req", {ddr.wr_burst_req, ddr.rd_burst_req}, we ? 2'b10 : 2'b01);
            check("dn_addr", we ? ddr.wr_burst_addr : ddr.rd_burst_addr, addr);
            check("dn_len", we ? ddr.wr_burst_len : ddr.rd_burst_len, 10'(exp_len));
            for (int w = 0; w < exp_len; w++) begin
                if (we) begin
                    ddr.wr_burst_data_req = 1'b1;
                    port_wdata[p*32 +: 32] = 32'hC0DE_0000 + 32'(w);
                end else begin
                    ddr.rd_burst_data_valid = 1'b1;
                    ddr.rd_burst_data = 32'hD000_0000 + 32'(w);
                end
                #1;
                if (we && port_wdata_req == onehot(p) && ddr.wr_burst_data == 32'hC0DE_0000 + 32'(w)) words++;
                if (!we && port_rdata_valid == onehot(p) && port_rdata == 32'hD000_0000 + 32'(w)) words++;
                tick();
            end
            ddr.wr_burst_data_req = 1'b0;
            ddr.rd_burst_data_valid = 1'b0;
            if (we) ddr.rd_burst_finish = 1'b1; else ddr.wr_burst_finish = 1'b1;
            tick();
            ddr.rd_burst_finish = 1'b0; ddr.wr_burst_finish = 1'b0;
            check("other_fin_ignored", {ddr.wr_burst_req, ddr.rd_burst_req}, we ? 2'b10 : 2'b01);
            if (we) ddr.wr_burst_finish = 1'b1; else ddr.rd_burst_finish = 1'b1;
            tick();
            ddr.rd_burst_finish = 1'b0; ddr.wr_burst_finish = 1'b0;
            check("dn_req_drop", {ddr.wr_burst_req, ddr.rd_burst_req}, 2'b00);
            check("finish_early", port_finish, '0);
            tick();
            check("finish_pulse", port_finish, onehot(p));
        end
        check("grant_cleared", port_grant, '0);
        if (!keep_req) port_req[p] = 1'b0;
        model_ptr = (p + 1) % N;
        tick();
        check("finish_one_cycle", port_finish, '0);
    endtask

    // Routing rules checked every cycle against the model's expected owner.
    task automatic cmp_cycle();
        logic [N-1:0] oh;
        oh = '0;
        if (port_grant != '0) oh[exp_owner] = 1'b1;
        check("cmp_grant", port_grant, oh);
        check("cmp_wdata_req", port_wdata_req, (ddr.wr_burst_data_req && exp_we) ? oh : '0);
        check("cmp_rdata_valid", port_rdata_valid, (ddr.rd_burst_data_valid && !exp_we) ? oh : '0);
        check("cmp_rdata", port_rdata, ddr.rd_burst_data);
        if (oh != '0) check("cmp_wr_data", ddr.wr_burst_data, port_wdata[exp_owner*32 +: 32]);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int words;
        int waited;
        int wnr;
        int order [5];
        order = '{0, 1, 2, 3, 0};

        fork
            forever begin
                @(negedge phy_clk);
                if (chk_en) cmp_cycle();
            end
        join_none

        do_reset();

        // Single write on port 1
        set_port(1, 1'b1, 25'h100, 10'd256);
        wnr = model_winner(4'b0010, 4'b0010, model_ptr);
        check("model_single", wnr, 1);
        port_req = 4'b0010;
        run_burst(1, 1'b0, words, waited);
        check("single_grant_latency", waited, 1);
        check("single_words", words, 256);

        // Round-robin over all four ports, port 0 re-requesting at once
        do_reset();
        for (int p = 0; p < N; p++) set_port(p, 1'b1, 25'(p * 32'h1000), 10'd1);
        port_req = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            wnr = model_winner(port_req, port_we, model_ptr);
            check("rr_model_order", wnr, order[b]);
            run_burst(wnr, (b == 0), words, waited);
            check("rr_wait", waited, (b == 0) ? 1 : 0);
            check("rr_words", words, 1);
        end

        // Read routing on port 2
        set_port(2, 1'b0, 25'h2000, 10'd8);
        port_req = 4'b0100;
        run_burst(2, 1'b0, words, waited);
        check("read_words", words, 8);

        // Zero-length request
        set_port(3, 1'b1, 25'h3000, 10'd0);
        port_req = 4'b1000;
        run_burst(3, 1'b0, words, waited);

        // Over-long read is clamped
        set_port(0, 1'b0, 25'h4000, 10'd600);
        port_req = 4'b0001;
        run_burst(0, 1'b0, words, waited);
        check("clamp_words", words, 256);

        // No arbitration before DDR init completes
        ddr_init_done = 1'b0;
        set_port(1, 1'b1, 25'h5000, 10'd2);
        port_req = 4'b0010;
        for (int i = 0; i < 10; i++) tick();
        check("init_low_no_grant", port_grant, '0);
        check("init_low_no_req", {ddr.wr_burst_req, ddr.rd_burst_req}, 2'b00);
        ddr_init_done = 1'b1;
        run_burst(1, 1'b0, words, waited);
        check("init_release_words", words, 2);

        // Reset in the middle of a burst
        set_port(2, 1'b1, 25'h6000, 10'd10);
        port_req = 4'b0100;
        exp_owner = 2; exp_we = 1'b1; chk_en = 1'b1;
        waited = 0;
        while (port_grant == '0 && waited < 20) begin tick(); waited++; end
        tick();
        check("mid_busy_req", ddr.wr_burst_req, 1'b1);
        ddr.wr_burst_data_req = 1'b1;
        tick(); tick();
        chk_en = 1'b0;
        rst = 1'b1;
        ddr.wr_burst_data_req = 1'b0;
        set_port(1, 1'b1, 25'h7100, 10'd1);
        set_port(3, 1'b1, 25'h7300, 10'd1);
        port_req = 4'b1110;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        model_ptr = 0;
        wnr = model_winner(port_req, port_we, model_ptr);
        check("midrst_model", wnr, 1);
        for (int i = 0; i < 4 && port_req != '0; i++) begin
            wnr = model_winner(port_req, port_we, model_ptr);
            run_burst(wnr, 1'b0, words, waited);
        end
        check("midrst_drained", port_req, '0);

        // Read vs write priority
        do_reset();
        set_port(0, 1'b1, 25'h8000, 10'd1);
        set_port(3, 1'b0, 25'h8300, 10'd1);
        port_req = 4'b1001;
        wnr = model_winner(port_req, port_we, model_ptr);
`ifdef DDR_ARB_RD_PRIO_EN
        check("prio_model", wnr, 3);
`else
        check("prio_model", wnr, 0);
`endif
        run_burst(wnr, 1'b0, words, waited);
        wnr = model_winner(port_req, port_we, model_ptr);
        run_burst(wnr, 1'b0, words, waited);
        check("prio_drained", port_req, '0);

        chk_en = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
